matrix_mem_reader: RTL

- Avalon-MM read master that fetches an R x C matrix of 32-bit words from the on-chip RAM slave (14-bit word address, fixed read latency, no waitrequest).
- Presents the words in row-major order on a valid/ready stream toward the matrix datapath.
- Handles the RAM's fixed read latency with a credit-checked output FIFO, so stream backpressure never drops a word.

---
 rtl/matrix_pkg.sv | 32 +++
 rtl/matrix_mem_reader_if.sv | 41 ++++
 rtl/matrix_rd_fifo.sv | 68 ++++++
 rtl/matrix_mem_reader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared constants and types for the matrix memory reader.
//   ADDR_W  : word address width of the RAM port (14)
//   DATA_W  : RAM / stream word width (32)
//   DIM_W   : width of the row and column counts (8)
// Types: mem_addr_t, mem_word_t, dim_t, reader_state_t, rd_tag_t.
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DIM_W  = 8;

  typedef logic [ADDR_W-1:0] mem_addr_t;
  typedef logic [DATA_W-1:0] mem_word_t;
  typedef logic [DIM_W-1:0]  dim_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } reader_state_t;

  // Per-word side information carried alongside the data word.
  typedef struct packed {
    logic eol;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/matrix_mem_reader_if.sv
// -----------------------------------------------------------------------------
// matrix_mem_reader_if
// Bundles the Avalon-MM read port toward the on-chip RAM and the valid/ready
// output stream toward the matrix datapath.
//   master : the reader side (drives address/chipselect and the stream)
//   slave  : the RAM + stream-sink side
// -----------------------------------------------------------------------------
interface matrix_mem_reader_if;
  import matrix_pkg::*;

  // memory port
  mem_addr_t  address;
  logic       chipselect;
  logic       write;
  mem_word_t  writedata;
  logic [3:0] byteenable;
  logic       clken;
  mem_word_t  readdata;

  // output stream
  mem_word_t  out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_eol;
  logic       out_last;

  modport master (
    output address, chipselect, write, writedata, byteenable, clken,
    input  readdata,
    output out_data, out_valid, out_eol, out_last,
    input  out_ready
  );

  modport slave (
    input  address, chipselect, write, writedata, byteenable, clken,
    output readdata,
    input  out_data, out_valid, out_eol, out_last,
    output out_ready
  );

endinterface

// File: rtl/matrix_rd_fifo.sv
// -----------------------------------------------------------------------------
// matrix_rd_fifo
// Small synchronous show-ahead FIFO holding {eol, last, data} words.
//   clk, reset : clock and synchronous active-high reset
//   push       : write push_data this cycle (caller guarantees space)
//   pop        : consume the head word (ignored when empty)
//   pop_data   : head word, valid whenever empty is low
//   count      : number of stored words
//   empty      : no stored words
// -----------------------------------------------------------------------------
module matrix_rd_fifo
  import matrix_pkg::*;
#(
  parameter int WIDTH = DATA_W + 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             pop_ok;

  assign pop_ok   = pop && (count_reg != '0);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  // Show-ahead: the head entry is never overwritten while occupied because
  // the writer only pushes when a slot is free.
  assign pop_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/matrix_mem_reader.sv
// -----------------------------------------------------------------------------
// matrix_mem_reader
// Avalon-MM read master that walks an R x C matrix in RAM and streams the
// words out row-major on a valid/ready interface. Reads are only issued when
// the output FIFO is guaranteed to have room for them, so backpressure never
// drops a word even though the RAM has a fixed, unstallable read latency.
// Address/data/dim widths come from matrix_pkg.
//
// Optional build macro: MATRIX_READER_TRANSPOSE_EN adds a 'transpose' input
// (latched on start) selecting column-major traversal.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start            : command strobe, sampled only in IDLE
//   base_addr        : word address of element (0,0)
//   rows, cols       : matrix dimensions
//   row_stride       : word distance between consecutive rows
//   transpose        : (optional) column-major traversal
//   busy             : command in progress
//   done             : one-cycle pulse after the last word left the stream
//   bus              : memory read port and output stream (master modport)
// -----------------------------------------------------------------------------
module matrix_mem_reader
  import matrix_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      start,
  input  mem_addr_t base_addr,
  input  dim_t      rows,
  input  dim_t      cols,
  input  mem_addr_t row_stride,
`ifdef MATRIX_READER_TRANSPOSE_EN
  input  logic      transpose,
`endif
  output logic      busy,
  output logic      done,
  matrix_mem_reader_if.master bus
);

  reader_state_t state_reg, state_next;
  logic          done_reg;

  dim_t      rows_reg, cols_reg;
  mem_addr_t stride_reg;
  // Address = outer_ptr + inner_off; the inner index runs fastest.
  mem_addr_t outer_ptr_reg, inner_off_reg;
  dim_t      inner_cnt_reg, outer_cnt_reg;

  mem_addr_t inner_step, outer_step;
  dim_t      inner_max, outer_max;

`ifdef MATRIX_READER_TRANSPOSE_EN
  logic transpose_reg;
  assign inner_step = transpose_reg ? stride_reg : mem_addr_t'(1);
  assign outer_step = transpose_reg ? mem_addr_t'(1) : stride_reg;
  assign inner_max  = transpose_reg ? rows_reg : cols_reg;
  assign outer_max  = transpose_reg ? cols_reg : rows_reg;
`else
  assign inner_step = mem_addr_t'(1);
  assign outer_step = stride_reg;
  assign inner_max  = cols_reg;
  assign outer_max  = rows_reg;
`endif

  logic    inner_last, outer_last, issue, credit_ok;
  rd_tag_t issue_tag;
  logic    vld_sr_reg [READ_LATENCY];
  rd_tag_t tag_sr_reg [READ_LATENCY];
  int      inflight_cnt;

  logic [DATA_W+1:0]           fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_empty;
  logic                        fifo_pop;

  assign inner_last     = (inner_cnt_reg == inner_max - dim_t'(1));
  assign outer_last     = (outer_cnt_reg == outer_max - dim_t'(1));
  assign issue_tag.eol  = inner_last;
  assign issue_tag.last = inner_last && outer_last;

  always_comb begin
    inflight_cnt = 0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      if (vld_sr_reg[i]) inflight_cnt++;
    end
  end

  // Every read already in flight or buffered owns a FIFO slot; a new read is
  // allowed only if a slot remains for it, ignoring any pop this cycle.
  assign credit_ok = (int'(fifo_count) + inflight_cnt + 1) <= FIFO_DEPTH;
  assign issue     = (state_reg == ISSUE) && credit_ok;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (rows == '0 || cols == '0) ? FIN : ISSUE;
      ISSUE:   if (issue && inner_last && outer_last) state_next = DRAIN;
      DRAIN:   if (fifo_empty && inflight_cnt == 0) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      done_reg      <= 1'b0;
      rows_reg      <= '0;
      cols_reg      <= '0;
      stride_reg    <= '0;
      outer_ptr_reg <= '0;
      inner_off_reg <= '0;
      inner_cnt_reg <= '0;
      outer_cnt_reg <= '0;
`ifdef MATRIX_READER_TRANSPOSE_EN
      transpose_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      // done follows FIN by one cycle, so it lands when busy has dropped.
      done_reg  <= (state_reg == FIN);
      if (state_reg == IDLE && start) begin
        rows_reg      <= rows;
        cols_reg      <= cols;
        stride_reg    <= row_stride;
        outer_ptr_reg <= base_addr;
        inner_off_reg <= '0;
        inner_cnt_reg <= '0;
        outer_cnt_reg <= '0;
`ifdef MATRIX_READER_TRANSPOSE_EN
        transpose_reg <= transpose;
`endif
      end else if (issue) begin
        if (inner_last) begin
          inner_cnt_reg <= '0;
          inner_off_reg <= '0;
          outer_cnt_reg <= outer_cnt_reg + dim_t'(1);
          outer_ptr_reg <= outer_ptr_reg + outer_step;
        end else begin
          inner_cnt_reg <= inner_cnt_reg + dim_t'(1);
          inner_off_reg <= inner_off_reg + inner_step;
        end
      end
    end
  end

  // Delay line matching the RAM latency: marks which cycles carry read data
  // and keeps each word's tags aligned with it.
  generate
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) begin
            vld_sr_reg[0] <= 1'b0;
            tag_sr_reg[0] <= '0;
          end else begin
            vld_sr_reg[0] <= issue;
            tag_sr_reg[0] <= issue_tag;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (reset) begin
            vld_sr_reg[gi] <= 1'b0;
            tag_sr_reg[gi] <= '0;
          end else begin
            vld_sr_reg[gi] <= vld_sr_reg[gi-1];
            tag_sr_reg[gi] <= tag_sr_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign fifo_pop = bus.out_valid && bus.out_ready;

  matrix_rd_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_sr_reg[READ_LATENCY-1]),
    .push_data ({tag_sr_reg[READ_LATENCY-1], bus.readdata}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign busy = (state_reg != IDLE);
  assign done = done_reg;

  assign bus.address    = outer_ptr_reg + inner_off_reg;
  assign bus.chipselect = issue;
  assign bus.write      = 1'b0;
  assign bus.writedata  = '0;
  assign bus.byteenable = 4'hF;
  assign bus.clken      = 1'b1;

  // Tags are gated so stale FIFO contents never show while the stream is idle.
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_rd_data[DATA_W-1:0];
  assign bus.out_last  = !fifo_empty && fifo_rd_data[DATA_W];
  assign bus.out_eol   = !fifo_empty && fifo_rd_data[DATA_W+1];

endmodule
